// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: issue-stage hazard controller for a short in-order pipeline
// without bypassing. It holds two in-flight destination slots (EX, WB) and
// inserts NOP bubbles on read-after-write hazards. It squashes the offered
// instruction when a branch is taken and drains/halts the pipe on HALT.
//
// Ports
//   clk          : system clock, rising edge
//   rst          : asynchronous reset, active low
//   instr_in     : fetched instruction offered for issue (27 bits)
//   instr_valid  : instr_in holds a real instruction
//   branch_taken : branch/jump in execute resolved taken this cycle
//   resume       : single-cycle pulse releasing the halted state
//   instr_out    : instruction issued to the decoder, 27'd0 is the NOP bubble
//   pc_stall     : hold PC and instr_in this cycle
//   flush        : offered instruction squashed this cycle
//   halted       : pipeline drained after HALT
//   stall_cnt    : hazard-stall cycle count, saturating
//   flush_cnt    : flush cycle count, saturating
module pipe_hazard_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [26:0] instr_in,
   input  logic        instr_valid,
   input  logic        branch_taken,
   input  logic        resume,
   output logic [26:0] instr_out,
   output logic        pc_stall,
   output logic        flush,
   output logic        halted,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt
);

   // Opcode map, instr[26:22]
   localparam logic [4:0] OpInv  = 5'b01001;
   localparam logic [4:0] OpMov  = 5'b01010;
   localparam logic [4:0] OpBeq  = 5'b01011;
   localparam logic [4:0] OpBneq = 5'b01100;
   localparam logic [4:0] OpHalt = 5'b10000;
   localparam logic [4:0] OpImm9 = 5'b11001; // hole in the immediate range
   localparam logic [4:0] OpMovi = 5'b11010;
   localparam logic [4:0] OpSys  = 5'b11111;

   typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

   // {wen, waddr} of the register an instruction writes
   function automatic logic [3:0] dst_info(input logic [26:0] ins);
      logic [4:0] op;
      op = ins[26:22];
      dst_info = 4'd0;
      if ((op >= 5'd1) && (op <= 5'd10)) begin
         dst_info = {1'b1, ins[21:19]};
      end else if ((op >= 5'd17) && (op <= 5'd26) && (op != OpImm9)) begin
         dst_info = {1'b1, ins[21:19]};
      end else if ((op == OpSys) && !ins[20]) begin
         dst_info = {1'b1, ins[19:17]};
      end
   endfunction

   // {v1, a1, v2, a2}: up to two source registers an instruction reads
   function automatic logic [7:0] src_info(input logic [26:0] ins);
      logic [4:0] op;
      op = ins[26:22];
      src_info = 8'd0;
      if (op == OpInv) begin
         src_info = {1'b1, ins[18:16], 4'd0};
      end else if (op == OpMov) begin
         src_info = {4'd0, 1'b1, ins[2:0]};
      end else if ((op >= 5'd1) && (op <= 5'd8)) begin
         src_info = {1'b1, ins[18:16], 1'b1, ins[2:0]};
      end else if ((op >= 5'd17) && (op <= 5'd24)) begin
         src_info = {1'b1, ins[18:16], 4'd0};
      end else if ((op == OpBeq) || (op == OpBneq)) begin
         src_info = {1'b1, ins[21:19], 1'b1, ins[18:16]};
      end else if ((op == OpSys) && ins[20]) begin
         src_info = {1'b1, ins[19:17], 4'd0};
      end
   endfunction

   state_e      state_q, state_d;
   logic [1:0]  drain_q, drain_d;
   logic [3:0]  ex_q, wb_q;            // {wen, waddr}
   logic [15:0] stall_cnt_q, flush_cnt_q;
   logic        stall_inc, flush_inc;
   logic [7:0]  src;
   logic        hit1, hit2, hazard;

   assign src  = src_info(instr_in);
   assign hit1 = src[7] && ((ex_q[3] && (ex_q[2:0] == src[6:4])) ||
                            (wb_q[3] && (wb_q[2:0] == src[6:4])));
   assign hit2 = src[3] && ((ex_q[3] && (ex_q[2:0] == src[2:0])) ||
                            (wb_q[3] && (wb_q[2:0] == src[2:0])));
   assign hazard = instr_valid && (hit1 || hit2);

   always_comb begin
      instr_out = 27'd0;
      pc_stall  = 1'b0;
      flush     = 1'b0;
      stall_inc = 1'b0;
      flush_inc = 1'b0;
      state_d   = state_q;
      drain_d   = drain_q;
      unique case (state_q)
         StRun: begin
            if (branch_taken) begin
               flush     = 1'b1;
               flush_inc = 1'b1;
            end else if (!instr_valid) begin
               instr_out = 27'd0;
            end else if (hazard) begin
               pc_stall  = 1'b1;
               stall_inc = 1'b1;
            end else begin
               instr_out = instr_in;
               if (instr_in[26:22] == OpHalt) begin
                  state_d = StDrain;
                  drain_d = 2'd0;
               end
            end
         end
         StDrain: begin
            pc_stall = 1'b1;
            if (drain_q == 2'd1) begin
               state_d = StHalted;
               drain_d = 2'd0;
            end else begin
               drain_d = drain_q + 2'd1;
            end
         end
         StHalted: begin
            pc_stall = 1'b1;
            if (resume) begin
               state_d = StRun;
            end
         end
         default: begin
            state_d = StRun;
            drain_d = 2'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StRun;
         drain_q     <= 2'd0;
         ex_q        <= 4'd0;
         wb_q        <= 4'd0;
         stall_cnt_q <= 16'd0;
         flush_cnt_q <= 16'd0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         // A bubble (27'd0) decodes as a non-writer, so wen stays 0
         ex_q    <= dst_info(instr_out);
         wb_q    <= ex_q;
         if (stall_inc && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
         end
         if (flush_inc && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_q <= flush_cnt_q + 16'd1;
         end
      end
   end

   assign halted    = (state_q == StHalted);
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule
